// File: rtl/nubus_arbiter.sv
// NuBus distributed arbitration stage: drives /ARB and /RQST enables from the slot ID
// and returns arb_grant to the master once this card holds the bus.
module nubus_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       nub_clkn,
    input  logic       nub_reset,
    input  logic [3:0] nub_idn,
    input  logic [3:0] nub_arbn,
    input  logic       nub_startn,
    input  logic       arb_enable,
    output logic [3:0] arb_drv,
    output logic       rqst_drv,
    output logic       arb_grant
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WON,
        LOST
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       arb_q;
    logic             start_q;
    logic [3:0]       arb_drv_q;
    logic             rqst_drv_q;
    logic             arb_grant_q;

    logic [3:0]       id;
    logic [3:0]       prio_d;

    assign id = ~nub_idn;

    // A bit of our ID may be driven only while no higher bus bit is asserted
    // by a contender whose ID has that bit set and ours does not.
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        logic higher_ok;
        prio_d    = '0;
        higher_ok = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            prio_d[k] = id[k] & higher_ok;
            higher_ok = higher_ok & (id[k] | ~arb_q[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            arb_q       <= '0;
            start_q     <= 1'b0;
            arb_drv_q   <= '0;
            rqst_drv_q  <= 1'b0;
            arb_grant_q <= 1'b0;
        end else begin
            arb_q   <= ~nub_arbn;
            start_q <= ~nub_startn;

            case (state_q)
                IDLE: begin
                    arb_grant_q <= 1'b0;
                    if (arb_enable) begin
                        state_q    <= SETTLE;
                        cnt_q      <= '0;
                        arb_drv_q  <= prio_d;
                        rqst_drv_q <= 1'b1;
                    end else begin
                        arb_drv_q  <= '0;
                        rqst_drv_q <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (!arb_enable) begin
                        state_q     <= IDLE;
                        arb_drv_q   <= '0;
                        rqst_drv_q  <= 1'b0;
                        arb_grant_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        if (arb_q == id) begin
                            state_q     <= WON;
                            arb_drv_q   <= id;
                            arb_grant_q <= 1'b1;
                        end else begin
                            state_q   <= LOST;
                            arb_drv_q <= '0;
                        end
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        arb_drv_q <= prio_d;
                    end
                end

                WON: begin
                    if (!arb_enable) begin
                        state_q     <= IDLE;
                        arb_drv_q   <= '0;
                        rqst_drv_q  <= 1'b0;
                        arb_grant_q <= 1'b0;
                    end else if (start_q) begin
                        rqst_drv_q <= 1'b0;
                    end
                end

                LOST: begin
                    if (!arb_enable) begin
                        state_q    <= IDLE;
                        arb_drv_q  <= '0;
                        rqst_drv_q <= 1'b0;
                    end else if (start_q) begin
                        // The winner's START reopens arbitration for everyone who backed off.
                        state_q   <= SETTLE;
                        cnt_q     <= '0;
                        arb_drv_q <= prio_d;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    arb_drv_q   <= '0;
                    rqst_drv_q  <= 1'b0;
                    arb_grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb_drv   = arb_drv_q;
    assign rqst_drv  = rqst_drv_q;
    assign arb_grant = arb_grant_q;

endmodule
